// File: rtl/mul_writeback_unit_if.sv
// Operand/result bundle between the register file and the shift-add multiplier.
// The register file side is the master and the multiplier side is the slave.
interface mul_writeback_unit_if #(
    parameter int WIDTH = 64
);
    // Handshake: start acts as valid and !busy acts as ready. A request is
    // accepted only on a rising edge where start=1 and busy=0. Operands,
    // dest_reg and hi_sel need to be valid only on that edge. done and
    // RegWrite are one-cycle pulses that need no acknowledge.
    logic             start;
    logic [WIDTH-1:0] ReadData1;
    logic [WIDTH-1:0] ReadData2;
    logic [4:0]       dest_reg;
    logic             hi_sel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] WriteData;
    logic [4:0]       WriteRegister;
    logic             RegWrite;

    modport master (
        output start, ReadData1, ReadData2, dest_reg, hi_sel,
        input  busy, done, WriteData, WriteRegister, RegWrite
    );

    modport slave (
        input  start, ReadData1, ReadData2, dest_reg, hi_sel,
        output busy, done, WriteData, WriteRegister, RegWrite
    );
endinterface

// File: rtl/mul_writeback_unit.sv
// Radix-2 shift-add unsigned multiplier. It returns the low half (MUL) or the
// high half (UMULH) of the 2*WIDTH product to the register file write port.
module mul_writeback_unit #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7     // 2**CNT_W must exceed WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    mul_writeback_unit_if.slave   bus,
    output logic [1:0]            state_dbg
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] XZR = 5'd31;

    logic [1:0]         state;
    logic [CNT_W-1:0]   counter;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH:0]     upper_sum;
    logic [4:0]         dest_q;
    logic               hi_q;
    logic               last_iter;

    logic               done_q;
    logic               reg_write_q;
    logic [WIDTH-1:0]   write_data_q;
    logic [4:0]         write_reg_q;

    // One shift-add step. The carry out of the upper-half add becomes the new
    // MSB after the right shift, so the exact 2*WIDTH product is kept.
    always_comb begin
        upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        acc_step  = acc >> 1;
        if (acc[0]) begin
            acc_step = {upper_sum, acc[WIDTH-1:1]};
        end
    end

    assign last_iter = (counter == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            counter      <= '0;
            acc          <= '0;
            mcand        <= '0;
            dest_q       <= '0;
            hi_q         <= 1'b0;
            done_q       <= 1'b0;
            reg_write_q  <= 1'b0;
            write_data_q <= '0;
            write_reg_q  <= '0;
        end else begin
            done_q      <= 1'b0;
            reg_write_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        mcand   <= bus.ReadData1;
                        acc     <= {{WIDTH{1'b0}}, bus.ReadData2};
                        dest_q  <= bus.dest_reg;
                        hi_q    <= bus.hi_sel;
                        counter <= '0;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc     <= acc_step;
                    counter <= counter + CNT_W'(1);
                    if (last_iter) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Writes to XZR are dropped, but done still pulses.
                    done_q       <= 1'b1;
                    reg_write_q  <= (dest_q != XZR);
                    write_data_q <= hi_q ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
                    write_reg_q  <= dest_q;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = (state == S_RUN) || (state == S_DONE);
    assign bus.done          = done_q;
    assign bus.RegWrite      = reg_write_q;
    assign bus.WriteData     = write_data_q;
    assign bus.WriteRegister = write_reg_q;
    assign state_dbg         = state;

    a_regwrite_needs_done: assert property (
        @(posedge clk) disable iff (reset) bus.RegWrite |-> bus.done
    );
    a_done_single_cycle: assert property (
        @(posedge clk) disable iff (reset) bus.done |=> !bus.done
    );
endmodule

// File: tb/tb_mul_writeback_unit.sv
// Directed bench for mul_writeback_unit: the drivers queue expected writebacks
// and a negedge monitor pops and compares them whenever done is seen.
module tb_mul_writeback_unit;
    localparam int WIDTH   = 64;
    localparam int LATENCY = 65;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [4:0]       rd;
        logic             we;
        int               cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [1:0] state_dbg;
    int         cyc;
    int         n_checks;
    int         n_fail;
    exp_t       exp_q[$];

    mul_writeback_unit_if #(.WIDTH(WIDTH)) bus ();

    mul_writeback_unit #(.WIDTH(WIDTH), .CNT_W(7)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // ---------------- drivers ----------------
    // Presents one request for a single edge. The caller chooses whether a
    // writeback is expected and whether the DUT should be busy afterwards.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [4:0] rd, input logic hi,
                         input logic push, input logic [WIDTH-1:0] exp_data);
        exp_t e;
        bus.start     = 1'b1;
        bus.ReadData1 = a;
        bus.ReadData2 = b;
        bus.dest_reg  = rd;
        bus.hi_sel    = hi;
        @(posedge clk);
        #1;
        if (push) begin
            e.data = exp_data;
            e.rd   = rd;
            e.we   = (rd != 5'd31);
            e.cyc  = cyc + LATENCY;
            exp_q.push_back(e);
        end
        bus.start     = 1'b0;
        bus.ReadData1 = {$urandom, $urandom};
        bus.ReadData2 = {$urandom, $urandom};
        bus.dest_reg  = 5'($urandom_range(0, 31));
        bus.hi_sel    = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("busy_after_start", WIDTH'(bus.busy), WIDTH'(1));
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = (exp_q.size() == 0) && !bus.busy;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL drain_timeout pending=%0d busy=%0b", exp_q.size(), bus.busy);
            exp_q.delete();
        end
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = bus.done;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_timeout got=0 exp=1");
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.RegWrite && !bus.done) begin
                n_checks++;
                n_fail++;
                $display("FAIL regwrite_without_done cyc=%0d", cyc);
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done RegWrite=%0b WriteData=%h cyc=%0d",
                             bus.RegWrite, bus.WriteData, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("WriteData", bus.WriteData, e.data);
                    check("WriteRegister", WIDTH'(bus.WriteRegister), WIDTH'(e.rd));
                    check("RegWrite", WIDTH'(bus.RegWrite), WIDTH'(e.we));
                    check("latency_cycle", WIDTH'(cyc), WIDTH'(e.cyc));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.ReadData1 = '0;
        bus.ReadData2 = '0;
        bus.dest_reg  = '0;
        bus.hi_sel    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", WIDTH'(bus.busy), '0);
        check("reset_done", WIDTH'(bus.done), '0);
        check("reset_regwrite", WIDTH'(bus.RegWrite), '0);
        check("reset_wdata", bus.WriteData, '0);
        check("reset_wreg", WIDTH'(bus.WriteRegister), '0);

        // Basic low-half product
        issue(64'd3, 64'd5, 5'd2, 1'b0, 1'b1, 64'd15);
        wait_drain();

        // All-ones times two: product is 0x1_FFFF_FFFF_FFFF_FFFE
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 1'b1, 1'b1, 64'h1);
        wait_drain();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
        wait_drain();

        // (2^64-1)^2 = 2^128 - 2^65 + 1, which needs the carry into the MSB
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, 1'b1, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFE);
        wait_drain();
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 1'b0, 1'b1, 64'h1);
        wait_drain();

        // A second start during RUN is dropped
        issue(64'd7, 64'd9, 5'd3, 1'b0, 1'b1, 64'd63);
        repeat (8) @(negedge clk);
        bus.start     = 1'b1;
        bus.ReadData1 = 64'd100;
        bus.ReadData2 = 64'd100;
        bus.dest_reg  = 5'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_drain();

        // XZR destination: done pulses with no RegWrite
        issue(64'd4, 64'd4, 5'd31, 1'b0, 1'b1, 64'd16);
        wait_drain();

        // Reset in the middle of RUN aborts the operation
        issue(64'd11, 64'd13, 5'd12, 1'b0, 1'b0, '0);
        repeat (18) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_busy", WIDTH'(bus.busy), '0);
        check("abort_done", WIDTH'(bus.done), '0);
        check("abort_regwrite", WIDTH'(bus.RegWrite), '0);
        check("abort_wdata", bus.WriteData, '0);
        check("abort_wreg", WIDTH'(bus.WriteRegister), '0);

        // Restart right after the abort, then issue back-to-back in the done cycle
        issue(64'd6, 64'd7, 5'd10, 1'b0, 1'b1, 64'd42);
        wait_done();
        issue(64'h8000_0000_0000_0000, 64'd4, 5'd11, 1'b1, 1'b1, 64'd2);
        wait_done();
        issue(64'h1234_5678, 64'h10, 5'd9, 1'b0, 1'b1, 64'h1_2345_6780);
        wait_drain();

        // Quiet period: any stray done now shows up in the monitor
        repeat (80) @(negedge clk);
        check("final_queue_empty", WIDTH'(exp_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_writeback_unit.md
Name: mul_writeback_unit

Overview:
Multi-cycle 64-bit unsigned multiplier sitting directly downstream of the register file. Consumes the two register read operands (ReadData1/ReadData2) and computes the 128-bit product by radix-2 shift-add. Presents the selected 64-bit half back to the register file write port as WriteData/WriteRegister with a one-cycle RegWrite pulse. Serves ARM MUL (low half) and UMULH (high half).

Parameters:
WIDTH, 64, operand width in bits; product is 2*WIDTH; iteration count equals WIDTH.
CNT_W, 7, counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; one clock, synchronous active-high reset named clk/reset as in the rest of the codebase
start  input  1  request a multiply; sampled only in IDLE
ReadData1  input  WIDTH  multiplicand operand A
ReadData2  input  WIDTH  multiplier operand B
dest_reg  input  5  destination register number
hi_sel  input  1  0 = return product[WIDTH-1:0], 1 = return product[2*WIDTH-1:WIDTH]
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
WriteData  output  WIDTH  result to register file
WriteRegister  output  5  destination to register file
RegWrite  output  1  one-cycle write enable to register file

Behaviour:
- States: IDLE, RUN, DONE. Registered state, counter, acc (2*WIDTH bits), mcand (WIDTH), latched dest_reg and hi_sel.
- Reset (synchronous, has priority over everything): state=IDLE, counter=0, acc=0, mcand=0; busy=0, done=0, RegWrite=0, WriteData=0, WriteRegister=0. Reset during RUN or DONE aborts; no RegWrite is issued.
- IDLE: if start=1 at edge -> latch mcand=ReadData1, acc={WIDTH'b0, ReadData2}, dest_reg, hi_sel; counter=0; go RUN. start=0 -> stay IDLE.
- RUN, each cycle: if acc[0]=1, upper = acc[2*WIDTH-1:WIDTH] + mcand with carry out kept (WIDTH+1 bits); acc = {carry, upper, acc[WIDTH-1:1]} (right shift by one, carry into MSB). Else acc = acc >> 1. counter increments. After WIDTH iterations (counter reaches WIDTH-1 on the final update) go DONE.
- DONE (exactly one cycle): done=1; WriteData = hi_sel ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0]; WriteRegister = latched dest; RegWrite=1 unless latched dest=31 (XZR), then RegWrite=0 while done still pulses. Next state IDLE.
- Outside DONE: done=0, RegWrite=0; WriteData/WriteRegister hold the last result (0 after reset).
- Latency: start sampled at edge N -> done/RegWrite high during cycle N+WIDTH+1 (65 cycles for WIDTH=64). Throughput: new start accepted in the cycle after DONE (IDLE), i.e. one op per WIDTH+2 cycles.
- start while busy=1 (RUN or DONE) is ignored, not queued; operands on ReadData1/2 are don't-care after the latch cycle.
- Arithmetic is unsigned, exact 128-bit; no overflow flag. Zero operands still take full latency.

Test Plan:
- reset, start with A=3, B=5, dest=2, hi_sel=0 -> busy next cycle; RegWrite=1, WriteData=15, WriteRegister=2 exactly 65 cycles after start edge, done single cycle.
- A=0xFFFFFFFFFFFFFFFF, B=2, hi_sel=1 -> WriteData=0x1; repeat hi_sel=0 -> WriteData=0xFFFFFFFFFFFFFFFE.
- A=B=0xFFFFFFFFFFFFFFFF, hi_sel=1 -> WriteData=0xFFFFFFFFFFFFFFFE; hi_sel=0 -> 0x1 (exercises carry into MSB).
- start A=7,B=9 then pulse start with A=100,B=100 at cycle 10 of RUN -> result 63, only one RegWrite, second request dropped.
- dest=31, A=4, B=4 -> done=1 at cycle 65, RegWrite stays 0 throughout.
- reset asserted at cycle 20 of RUN -> next cycle busy=0, all outputs 0, no RegWrite ever; then start A=6,B=7 in next IDLE cycle -> WriteData=42 after 65 cycles; back-to-back start the cycle after done also accepted.
